// File: rtl/count_cmd_sequencer_pkg.sv
// count_seq_pkg: shared FSM state type, default width and reference shortest-path helper
package count_seq_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {IDLE, STEP, LOAD, CHECK} state_t;
   typedef struct packed {
      logic                 dir;
      logic [DEF_WIDTH-1:0] steps;
   } path_t;
   // Direction and step count from cur to tgt; a half-turn tie goes up.
   function automatic path_t shortest_path(input logic [DEF_WIDTH-1:0] cur, input logic [DEF_WIDTH-1:0] tgt);
      logic [DEF_WIDTH-1:0] diff;
      path_t p;
      diff = tgt - cur;
      p.dir = diff <= (DEF_WIDTH'(1) << (DEF_WIDTH-1));
      p.steps = p.dir ? diff : DEF_WIDTH'(0) - diff;
      return p;
   endfunction
endpackage

// File: rtl/count_cmd_sequencer_if.sv
// count_cmd_sequencer_if: target handshake, counter drive and status bundle; slave = sequencer
interface count_cmd_sequencer_if #(parameter int WIDTH = 4);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_value;
   logic             tgt_jump;
   logic             abort;
   logic             cnt_load;
   logic             cnt_up_down;
   logic [WIDTH-1:0] cnt_d_in;
   logic [WIDTH-1:0] cnt_d_out;
   logic             busy;
   logic             done;
   logic             err;
   logic             aborted;
   modport slave (
      input  tgt_valid, tgt_value, tgt_jump, abort, cnt_d_out,
      output tgt_ready, cnt_load, cnt_up_down, cnt_d_in, busy, done, err, aborted
   );
   modport master (
      output tgt_valid, tgt_value, tgt_jump, abort, cnt_d_out,
      input  tgt_ready, cnt_load, cnt_up_down, cnt_d_in, busy, done, err, aborted
   );
endinterface

// File: rtl/count_cmd_sequencer_path_calc.sv
// count_path_calc: modular distance cur->tgt as zero flag, direction (1=up) and step count
module count_path_calc #(parameter int WIDTH = 4) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] tgt,
   output logic             zero,
   output logic             dir,
   output logic [WIDTH-1:0] steps
);
   localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH-1);
   logic [WIDTH-1:0] diff;
   always_comb begin
      diff = tgt - cur;
      zero = diff == '0;
      dir = diff <= HALF;
      steps = dir ? diff : WIDTH'(0) - diff;
   end
endmodule

// File: rtl/up_down_counter.sv
// up_down_counter: loadable modulo-2^WIDTH up/down counter (load wins, else +1/-1)
module up_down_counter #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             up_down,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);
   always_ff @(posedge clk or posedge rst)
      if (rst) d_out <= '0;
      else d_out <= load ? d_in : up_down ? d_out + WIDTH'(1) : d_out - WIDTH'(1);
endmodule

// File: rtl/count_cmd_sequencer.sv
// count_cmd_sequencer: drives an up/down counter to a requested value by stepping or loading
// Ports: clk, rst (async high); bus (slave modport) carries target handshake, abort,
// counter load/up_down/d_in/d_out and busy/done/err/aborted status.
module count_cmd_sequencer
   import count_seq_pkg::*;
#(parameter int WIDTH = 4) (
   input logic                  clk,
   input logic                  rst,
   count_cmd_sequencer_if.slave bus
);
   state_t           state, nxt;
   logic [WIDTH-1:0] hold_q, tgt_q, steps_q, steps;
   logic             dir_q, dir, zero;
   count_path_calc #(.WIDTH(WIDTH)) u_calc (
      .cur(bus.cnt_d_out), .tgt(bus.tgt_value), .zero(zero), .dir(dir), .steps(steps)
   );
   wire accept = state == IDLE && bus.tgt_valid;
   wire stop = state == STEP && bus.abort;
   always_comb begin
      nxt = state;
      bus.cnt_load = 1'b1;
      bus.cnt_up_down = 1'b0;
      bus.cnt_d_in = hold_q;
      bus.tgt_ready = 1'b0;
      bus.done = 1'b0;
      bus.err = 1'b0;
      bus.aborted = 1'b0;
      case (state)
         IDLE: begin
            bus.tgt_ready = 1'b1;
            if (bus.tgt_valid) nxt = bus.tgt_jump ? LOAD : zero ? CHECK : STEP;
         end
         STEP: begin
            if (bus.abort) begin
               // freeze the counter where it stands
               bus.cnt_d_in = bus.cnt_d_out;
               bus.aborted = 1'b1;
               nxt = IDLE;
            end else begin
               bus.cnt_load = 1'b0;
               bus.cnt_up_down = dir_q;
               if (steps_q == WIDTH'(1)) nxt = CHECK;
            end
         end
         LOAD: begin
            bus.cnt_d_in = tgt_q;
            nxt = CHECK;
         end
         default: begin
            bus.cnt_d_in = tgt_q;
            bus.done = 1'b1;
            bus.err = bus.cnt_d_out != tgt_q;
            nxt = IDLE;
         end
      endcase
   end
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold_q <= '0;
         tgt_q <= '0;
         steps_q <= '0;
         dir_q <= 1'b0;
      end else begin
         if (accept) begin
            tgt_q <= bus.tgt_value;
            steps_q <= steps;
            dir_q <= dir;
         end
         if (state == STEP && !bus.abort) steps_q <= steps_q - WIDTH'(1);
         if (stop) hold_q <= bus.cnt_d_out;
         if (state == CHECK) hold_q <= tgt_q;
      end
endmodule
